corefifo_wr_ptr_ctrl: RTL and testbench
=======================================

Name: corefifo_wr_ptr_ctrl

Overview:
Write-side pointer controller for the dual-clock FIFO. It is the transmitting end of the gray-coded pointer crossing: it owns the binary write pointer and drives the memory write address. It publishes a registered gray write pointer to the read domain's N-stage synchronizer. It consumes the already-synchronized gray read pointer and produces full, almost-full, overflow and the write-side fill count, all in the single write clock domain.

Parameters:
ADDRWIDTH, 3, memory address width; depth = 2^ADDRWIDTH; pointers are ADDRWIDTH+1 bits (extra wrap bit).
AFULL_VAL, 6, afull asserts when fill count >= AFULL_VAL; legal range 1..2^ADDRWIDTH.

Ports:
clk  in  1  write-domain clock.
srst  in  1  synchronous active-high reset.
we  in  1  write request from the user.
rd_ptr_gray_sync  in  ADDRWIDTH+1  read pointer, gray, already synchronized into the clk domain.
wen_mem  out  1  RAM write enable (combinational: we & ~full).
waddr  out  ADDRWIDTH  RAM write address = wbin[ADDRWIDTH-1:0].
wr_ptr_gray  out  ADDRWIDTH+1  registered gray write pointer, to the read-domain synchronizer.
full  out  1  registered full flag.
afull  out  1  registered almost-full flag.
overflow  out  1  registered one-cycle pulse when a write is rejected.
wrcnt  out  ADDRWIDTH+1  registered fill level as seen from the write side (0..2^ADDRWIDTH).

Behaviour:
- Clock and reset: one clock only. Reset is synchronous and active-high, on port srst, sampled at posedge clk. Reset dominates every other input in the same cycle.
- Reset values: wbin=0, wr_ptr_gray=0, full=0, afull=0, overflow=0, wrcnt=0.
- Write acceptance: accept = we & ~full. Then wbin_next = wbin + accept, modulo 2^(ADDRWIDTH+1). wbin is registered.
- Gray output: wr_ptr_gray <= wbin_next ^ (wbin_next >> 1). It is registered straight from the flops with no combinational path to the port. It changes in at most one bit per clock, which is mandatory for a safe crossing.
- Read pointer decode: rbin = gray-to-binary(rd_ptr_gray_sync), computed combinationally. rbin[MSB] = g[MSB]; rbin[i] = rbin[i+1] ^ g[i].
- Fill count: wrcnt <= wbin_next - rbin, modulo 2^(ADDRWIDTH+1). The result is always in 0..depth.
- full: full <= (gray(wbin_next) == {~g[MSB], ~g[MSB-1], g[MSB-2:0]}), where g = rd_ptr_gray_sync. This is equivalent to wrcnt_next == depth, and the two must agree every cycle.
- afull: afull <= (wbin_next - rbin) >= AFULL_VAL.
- Latency: a write accepted at edge k updates waddr, wr_ptr_gray, wrcnt and flags at edge k. An rd_ptr_gray_sync change at edge k is reflected in wrcnt, full and afull at edge k+1.
- Pessimism: full and afull deassert only after the read pointer has crossed the synchronizer (NUM_STAGES+1 read-side cycles plus 1 cycle here). This is correct and intended; they never assert late.
- Overflow: we & full -> overflow <= 1 for exactly one cycle per rejected cycle. wbin is held and wen_mem=0. overflow stays 0 whenever accept=1.
- Full boundary: with full=1, a read arriving in the same cycle as we does not admit the write that cycle. The write is admitted next cycle, once full has dropped.
- Wrap-around: wbin wraps from 2^(ADDRWIDTH+1)-1 to 0. The gray code wraps from 100..0 to 000..0, still a one-bit change. wrcnt stays correct across the wrap.
- Reset mid-operation: all pointers return to 0 on the next edge. The read side must be reset in the same window; a mismatch is not detected by this block.
- rd_ptr_gray_sync is assumed monotonic (forward only). No behaviour is defined for backward moves.

Test Plan:
- Reset with ADDRWIDTH=3, AFULL_VAL=6: assert srst for 2 cycles with we=1 -> all outputs 0, wen_mem=0 during reset, and wbin has not advanced after release.
- Fill to full with rd_ptr_gray_sync=0: 8 consecutive writes -> waddr steps 0..7, wr_ptr_gray steps 0,1,3,2,6,7,5,4,C. afull=1 after the 6th write, full=1 after the 8th, wrcnt=8.
- Overflow: at full, hold we=1 for 3 cycles -> overflow=1 for 3 cycles, wen_mem=0, wr_ptr_gray stays C, wrcnt stays 8.
- Drain release: at full, step rd_ptr_gray_sync to 1 (rbin=1) -> next cycle full=0, wrcnt=7, afull=1. Step it to 3 (rbin=2) -> wrcnt=6. Step it to 2 (rbin=3) -> wrcnt=5, afull=0.
- Wrap: run 40 writes with a read model trailing by 2 through a 2-stage sync -> wr_ptr_gray passes 8 -> 0 on the wrap. A checker confirms at most one bit flips per cycle and that wrcnt always equals the reference-model occupancy. full is never 1 while that occupancy is below 8.
- Simultaneous events: at wrcnt=7, we=1 in the same cycle rd_ptr_gray_sync advances by one -> wrcnt stays 7, full=0 and overflow=0.

Source files
------------

// File: rtl/corefifo_wr_ptr_ctrl_if.sv
// Write-side bus of the dual-clock FIFO pointer controller: user request,
// synchronized read pointer in, and RAM port, gray pointer and flags out.
interface corefifo_wr_ptr_ctrl_if #(
    parameter int ADDRWIDTH = 3
);
    logic                 we;
    logic [ADDRWIDTH:0]   rd_ptr_gray_sync;
    logic                 wen_mem;
    logic [ADDRWIDTH-1:0] waddr;
    logic [ADDRWIDTH:0]   wr_ptr_gray;
    logic                 full;
    logic                 afull;
    logic                 overflow;
    logic [ADDRWIDTH:0]   wrcnt;

    modport master (
        output we, rd_ptr_gray_sync,
        input  wen_mem, waddr, wr_ptr_gray, full, afull, overflow, wrcnt
    );

    modport slave (
        input  we, rd_ptr_gray_sync,
        output wen_mem, waddr, wr_ptr_gray, full, afull, overflow, wrcnt
    );
endinterface

// File: rtl/corefifo_wr_ptr_ctrl.sv
// Write-side pointer controller: owns the binary write pointer, publishes a
// registered gray pointer and derives full/afull/overflow/fill count.
module corefifo_wr_ptr_ctrl #(
    parameter int ADDRWIDTH = 3,
    parameter int AFULL_VAL = 6
) (
    input logic                    clk,
    input logic                    srst,
    corefifo_wr_ptr_ctrl_if.slave  bus
);
    localparam int PW = ADDRWIDTH + 1;
    localparam logic [PW-1:0] AFULL_TH  = PW'(AFULL_VAL);
    // Full when the write gray pointer equals the read gray pointer with its top two bits inverted.
    localparam logic [PW-1:0] FULL_MASK = {2'b11, {(ADDRWIDTH-1){1'b0}}};

    logic [PW-1:0] wbin_q, wbin_d;
    logic [PW-1:0] wgray_q, wgray_d;
    logic [PW-1:0] wrcnt_q, wrcnt_d;
    logic [PW-1:0] rbin;
    logic          full_q, full_d;
    logic          afull_q, afull_d;
    logic          overflow_q, overflow_d;
    logic          accept;

    // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
    always_comb begin
        rbin = '0;
        for (int i = 0; i < PW; i++) begin
            rbin[i] = ^(bus.rd_ptr_gray_sync >> i);
        end
    end

    always_comb begin
        accept     = bus.we & ~full_q & ~srst;
        wbin_d     = wbin_q + {{ADDRWIDTH{1'b0}}, accept};
        wgray_d    = wbin_d ^ (wbin_d >> 1);
        wrcnt_d    = wbin_d - rbin;
        full_d     = (wgray_d == (bus.rd_ptr_gray_sync ^ FULL_MASK));
        afull_d    = (wrcnt_d >= AFULL_TH);
        overflow_d = bus.we & full_q;
    end

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (srst) begin
            wbin_q     <= '0;
            wgray_q    <= '0;
            wrcnt_q    <= '0;
            full_q     <= 1'b0;
            afull_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            wbin_q     <= wbin_d;
            wgray_q    <= wgray_d;
            wrcnt_q    <= wrcnt_d;
            full_q     <= full_d;
            afull_q    <= afull_d;
            overflow_q <= overflow_d;
        end
    end

    assign bus.wen_mem     = accept;
    assign bus.waddr       = wbin_q[ADDRWIDTH-1:0];
    assign bus.wr_ptr_gray = wgray_q;
    assign bus.wrcnt       = wrcnt_q;
    assign bus.full        = full_q;
    assign bus.afull       = afull_q;
    assign bus.overflow    = overflow_q;
endmodule

// File: tb/tb_corefifo_wr_ptr_ctrl.sv
// Bench for corefifo_wr_ptr_ctrl: directed reset/fill/overflow/drain cases, then
// random traffic against a count-based occupancy model with a delayed read side.
module tb_corefifo_wr_ptr_ctrl;
    localparam int AW    = 3;
    localparam int PW    = AW + 1;
    localparam int DEPTH = 1 << AW;
    localparam int AFULL = 6;

    logic clk = 1'b0;
    logic srst;
    always #5 clk = ~clk;

    corefifo_wr_ptr_ctrl_if #(.ADDRWIDTH(AW)) bus ();

    corefifo_wr_ptr_ctrl #(.ADDRWIDTH(AW), .AFULL_VAL(AFULL)) dut (
        .clk  (clk),
        .srst (srst),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: total writes accepted and the registered full state.
    int wr_total = 0;
    bit m_full   = 1'b0;
    logic [PW-1:0] prev_gray;
    bit prev_valid = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [PW-1:0] to_gray(input int n);
        logic [PW-1:0] b;
        b = PW'(n % (2 * DEPTH));
        return b ^ (b >> 1);
    endfunction

    // One clock: drive inputs, check wen_mem, advance model, check registered outputs.
    task automatic cycle(input bit we_i, input int rd_i, input bit rst_i);
        int occ;
        int acc;
        bit ovf;
        srst                 = rst_i;
        bus.we               = we_i;
        bus.rd_ptr_gray_sync = to_gray(rd_i);
        #1;
        check("wen_mem", 32'(bus.wen_mem), 32'(we_i && !m_full && !rst_i));
        @(posedge clk);
        #1;
        if (rst_i) begin
            wr_total = 0;
            m_full   = 1'b0;
            occ      = 0;
            ovf      = 1'b0;
        end else begin
            acc      = (we_i && !m_full) ? 1 : 0;
            ovf      = we_i && m_full;
            wr_total = wr_total + acc;
            occ      = wr_total - rd_i;
            m_full   = (occ == DEPTH);
        end
        check("waddr",    32'(bus.waddr),       32'(wr_total % DEPTH));
        check("gray",     32'(bus.wr_ptr_gray), 32'(to_gray(wr_total)));
        check("wrcnt",    32'(bus.wrcnt),       32'(occ));
        check("full",     32'(bus.full),        32'(m_full));
        check("afull",    32'(bus.afull),       32'(occ >= AFULL));
        check("overflow", 32'(bus.overflow),    32'(ovf));
        if (!rst_i && prev_valid)
            check("gray_1bit", 32'($countones(prev_gray ^ bus.wr_ptr_gray) <= 1), 32'(1));
        prev_gray  = bus.wr_ptr_gray;
        prev_valid = !rst_i;
    endtask

    int rd_total;
    int rd_sync;
    bit we_r;
    int wr_hist[$];
    int rd_hist[$];

    initial begin
        srst                 = 1'b1;
        bus.we               = 1'b0;
        bus.rd_ptr_gray_sync = '0;
        @(posedge clk);
        #1;

        // Reset held with we=1 must not advance the pointer.
        cycle(1'b1, 0, 1'b1);
        cycle(1'b1, 0, 1'b1);

        // Fill to full with the read pointer parked at 0.
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b1, 0, 1'b0);
            if (i == AFULL - 1) check("afull_at_6", 32'(bus.afull), 32'(1));
        end
        check("fill_gray_c", 32'(bus.wr_ptr_gray), 32'hC);
        check("fill_full",   32'(bus.full),        32'(1));
        check("fill_wrcnt",  32'(bus.wrcnt),       32'(8));

        // Writes while full are rejected and flagged.
        repeat (3) begin
            cycle(1'b1, 0, 1'b0);
            check("ovf_pulse", 32'(bus.overflow),    32'(1));
            check("ovf_gray",  32'(bus.wr_ptr_gray), 32'hC);
        end

        // Drain release as the read pointer steps forward.
        cycle(1'b0, 1, 1'b0);
        check("drain1_full",  32'(bus.full),  32'(0));
        check("drain1_wrcnt", 32'(bus.wrcnt), 32'(7));
        check("drain1_afull", 32'(bus.afull), 32'(1));
        cycle(1'b0, 2, 1'b0);
        check("drain2_wrcnt", 32'(bus.wrcnt), 32'(6));
        cycle(1'b0, 3, 1'b0);
        check("drain3_wrcnt", 32'(bus.wrcnt), 32'(5));
        check("drain3_afull", 32'(bus.afull), 32'(0));

        // Simultaneous write and read at wrcnt=7.
        cycle(1'b1, 3, 1'b0);
        cycle(1'b1, 3, 1'b0);
        cycle(1'b1, 4, 1'b0);
        check("simul_wrcnt", 32'(bus.wrcnt),    32'(7));
        check("simul_full",  32'(bus.full),     32'(0));
        check("simul_ovf",   32'(bus.overflow), 32'(0));

        // Full boundary: a read arriving with a write at full does not admit it that cycle.
        cycle(1'b1, 4, 1'b0);
        cycle(1'b1, 5, 1'b0);
        check("bound_ovf",   32'(bus.overflow), 32'(1));
        check("bound_wrcnt", 32'(bus.wrcnt),    32'(7));
        cycle(1'b1, 5, 1'b0);
        check("bound_admit", 32'(bus.wrcnt),    32'(8));

        // Random traffic with a read side that sees writes and is seen through 2-stage syncs.
        rd_total = 5;
        repeat (2) begin
            wr_hist.push_back(wr_total);
            rd_hist.push_back(rd_total);
        end
        for (int i = 0; i < 300; i++) begin
            rd_sync = rd_hist[0];
            we_r    = ($urandom_range(0, 3) != 0);
            cycle(we_r, rd_sync, 1'b0);
            if (rd_total < wr_hist[0] && $urandom_range(0, 1) == 1) rd_total++;
            void'(wr_hist.pop_front());
            wr_hist.push_back(wr_total);
            void'(rd_hist.pop_front());
            rd_hist.push_back(rd_total);
        end
        check("wrapped", 32'(wr_total > 2 * DEPTH * 2), 32'(1));

        // Reset mid-operation, read side reset in the same window.
        cycle(1'b1, 0, 1'b1);
        check("rst_mid_wrcnt", 32'(bus.wrcnt), 32'(0));
        cycle(1'b1, 0, 1'b0);
        check("post_rst_wrcnt", 32'(bus.wrcnt), 32'(1));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
